// File: rtl/char_ram_console_ctrl_pkg.sv
// Shared definitions for the character RAM console write controller:
// control codes, FSM states, cursor operations and bus widths.
package char_console_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADV,
    CUR_NL,
    CUR_CR,
    CUR_BS,
    CUR_HOME
  } cur_op_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/char_ram_console_ctrl_if.sv
// Byte-stream handshake plus RAM write port of the console controller.
// master = byte producer / RAM side, slave = controller.
interface char_ram_console_ctrl_if;
  import char_console_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dia;

  modport master (
    output in_valid, in_data,
    input  in_ready, wea, addra, dia
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wea, addra, dia
  );
endinterface

// File: rtl/char_ram_console_ctrl_cursor.sv
// Cursor tracker: column, row and row base address (stepped by COLS,
// so the cell address needs only an adder).
module char_cursor import char_console_pkg::*; #(
  parameter int unsigned COLS = 40,
  parameter int unsigned ROWS = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  cur_op_t           i_op,
  output logic [5:0]        o_col,
  output logic [4:0]        o_row,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_row,
  output logic              o_last_cell,
  output logic              o_col_zero
);

  logic [5:0]        r_col;
  logic [4:0]        r_row;
  logic [ADDR_W-1:0] r_row_base;

  logic              w_last_col;
  logic              w_last_row;
  logic [4:0]        w_row_step;
  logic [ADDR_W-1:0] w_base_step;
  logic [5:0]        w_col_nxt;
  logic [4:0]        w_row_nxt;
  logic [ADDR_W-1:0] w_base_nxt;

  // Position flags, cell address and the wrapped next-row values.
  always_comb begin
    w_last_col = (r_col == 6'(COLS - 1));
    w_last_row = (r_row == 5'(ROWS - 1));
    if (w_last_row) begin
      w_row_step  = '0;
      w_base_step = '0;
    end else begin
      w_row_step  = r_row + 5'd1;
      w_base_step = r_row_base + ADDR_W'(COLS);
    end
  end

  assign o_col       = r_col;
  assign o_row       = r_row;
  assign o_addr      = r_row_base + ADDR_W'(r_col);
  assign o_last_row  = w_last_row;
  assign o_last_cell = w_last_col && w_last_row;
  assign o_col_zero  = (r_col == '0);

  // Next cursor position for the requested operation.
  always_comb begin
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    w_base_nxt = r_row_base;
    case (i_op)
      CUR_ADV: begin
        if (w_last_col) begin
          w_col_nxt  = '0;
          w_row_nxt  = w_row_step;
          w_base_nxt = w_base_step;
        end else begin
          w_col_nxt = r_col + 6'd1;
        end
      end
      CUR_NL: begin
        w_col_nxt  = '0;
        w_row_nxt  = w_row_step;
        w_base_nxt = w_base_step;
      end
      CUR_CR: w_col_nxt = '0;
      CUR_BS: begin
        if (r_col != '0) w_col_nxt = r_col - 6'd1;
      end
      CUR_HOME: begin
        w_col_nxt  = '0;
        w_row_nxt  = '0;
        w_base_nxt = '0;
      end
      default: ;
    endcase
  end

  // Cursor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else begin
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_row_base <= w_base_nxt;
    end
  end

endmodule

// File: rtl/char_ram_console_ctrl.sv
// Write-side controller for the 1024x8 character RAM: clear sweep after
// reset / form feed, then byte-stream decoding into RAM writes at the cursor.
// Optional macro CHAR_CONSOLE_AUTOCLR_EN: wrapping past the last row
// clears the screen instead of overwriting from row 0.
module char_ram_console_ctrl import char_console_pkg::*; #(
  parameter int unsigned COLS      = 40,
  parameter int unsigned ROWS      = 25,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  char_ram_console_ctrl_if.slave bus,
  output logic [5:0]             cur_col,
  output logic [4:0]             cur_row,
  output logic                   busy
);

  localparam int unsigned       CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
`ifdef CHAR_CONSOLE_AUTOCLR_EN
  localparam logic AUTOCLR = 1'b1;
`else
  localparam logic AUTOCLR = 1'b0;
`endif

  state_t            r_state,    w_state;
  logic [ADDR_W-1:0] r_sweep,    w_sweep;
  logic              r_wea,      w_wea;
  logic [ADDR_W-1:0] r_addra,    w_addra;
  logic [DATA_W-1:0] r_dia,      w_dia;
  logic              r_in_ready, w_in_ready;
  logic              r_busy,     w_busy;
  cur_op_t           w_cur_op;

  logic              w_accept;
  logic [ADDR_W-1:0] w_cur_addr;
  logic              w_last_row;
  logic              w_last_cell;
  logic              w_col_zero;

  char_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_op        (w_cur_op),
    .o_col       (cur_col),
    .o_row       (cur_row),
    .o_addr      (w_cur_addr),
    .o_last_row  (w_last_row),
    .o_last_cell (w_last_cell),
    .o_col_zero  (w_col_zero)
  );

  assign w_accept     = bus.in_valid && r_in_ready;
  assign bus.in_ready = r_in_ready;
  assign bus.wea      = r_wea;
  assign bus.addra    = r_addra;
  assign bus.dia      = r_dia;
  assign busy         = r_busy;

  // Next state, sweep counter, write port and cursor operation.
  always_comb begin
    w_state    = r_state;
    w_sweep    = r_sweep;
    w_wea      = 1'b0;
    w_addra    = r_addra;
    w_dia      = r_dia;
    w_in_ready = r_in_ready;
    w_busy     = r_busy;
    w_cur_op   = CUR_HOLD;
    case (r_state)
      ST_CLEAR: begin
        w_wea    = 1'b1;
        w_addra  = r_sweep;
        w_dia    = FILL_CHAR;
        w_cur_op = CUR_HOME;
        if (r_sweep == LAST_ADDR) begin
          w_state    = ST_IDLE;
          w_sweep    = '0;
          w_in_ready = 1'b1;
          w_busy     = 1'b0;
        end else begin
          w_sweep = r_sweep + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          if (is_printable(bus.in_data)) begin
            w_wea   = 1'b1;
            w_addra = w_cur_addr;
            w_dia   = bus.in_data;
            if (AUTOCLR && w_last_cell) begin
              w_cur_op   = CUR_HOME;
              w_state    = ST_CLEAR;
              w_sweep    = '0;
              w_in_ready = 1'b0;
              w_busy     = 1'b1;
            end else begin
              w_cur_op = CUR_ADV;
            end
          end else begin
            case (bus.in_data)
              CC_LF: begin
                if (AUTOCLR && w_last_row) begin
                  w_cur_op   = CUR_HOME;
                  w_state    = ST_CLEAR;
                  w_sweep    = '0;
                  w_in_ready = 1'b0;
                  w_busy     = 1'b1;
                end else begin
                  w_cur_op = CUR_NL;
                end
              end
              CC_CR: w_cur_op = CUR_CR;
              CC_BS: begin
                if (!w_col_zero) begin
                  w_wea    = 1'b1;
                  w_addra  = w_cur_addr - ADDR_W'(1);
                  w_dia    = FILL_CHAR;
                  w_cur_op = CUR_BS;
                end
              end
              CC_FF: begin
                w_cur_op   = CUR_HOME;
                w_state    = ST_CLEAR;
                w_sweep    = '0;
                w_in_ready = 1'b0;
                w_busy     = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state = ST_CLEAR;
    endcase
  end

  // State and output registers; reset restarts the clear sweep at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_sweep    <= '0;
      r_wea      <= 1'b0;
      r_addra    <= '0;
      r_dia      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_sweep    <= w_sweep;
      r_wea      <= w_wea;
      r_addra    <= w_addra;
      r_dia      <= w_dia;
      r_in_ready <= w_in_ready;
      r_busy     <= w_busy;
    end
  end

endmodule

// File: tb/tb_char_ram_console_ctrl.sv
// Directed bench for char_ram_console_ctrl (40x25 grid, fill 0x20).
module tb_char_ram_console_ctrl;
  import char_console_pkg::*;

  localparam int unsigned COLS  = 40;
  localparam int unsigned ROWS  = 25;
  localparam int unsigned CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  char_ram_console_ctrl_if bus();

  char_ram_console_ctrl #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .FILL_CHAR (8'h20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        wea;
    logic [13:0] addr;
    logic [7:0]  dia;
    logic [5:0]  col;
    logic [4:0]  row;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic wea, input logic [13:0] addr,
                            input logic [7:0] dia, input logic [5:0] col, input logic [4:0] row);
    chk({nm, ".wea"}, 32'(bus.wea), 32'(wea));
    if (wea) begin
      chk({nm, ".addra"}, 32'(bus.addra), 32'(addr));
      chk({nm, ".dia"}, 32'(bus.dia), 32'(dia));
    end
    chk({nm, ".col"}, 32'(cur_col), 32'(col));
    chk({nm, ".row"}, 32'(cur_row), 32'(row));
  endtask

  // Expects n consecutive fill writes at 0..n-1 with in_ready low until the last.
  task automatic sweep(input string nm, input int unsigned n);
    int unsigned errs  = 0;
    int unsigned first = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!(bus.wea === 1'b1 && bus.addra === 14'(i) && bus.dia === 8'h20 &&
            cur_col === 6'd0 && cur_row === 5'd0 &&
            (i == CELLS - 1 || bus.in_ready === 1'b0))) begin
        if (errs == 0) first = i;
        errs++;
      end
    end
    chk($sformatf("%s.sweep_errs(first_idx=%0d)", nm, first), errs, 0);
  endtask

  task automatic after_clear(input string nm);
    chk({nm, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".col"}, 32'(cur_col), 32'd0);
    chk({nm, ".row"}, 32'(cur_row), 32'd0);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, ".wea"}, 32'(bus.wea), 32'd0);
    chk({nm, ".addra"}, 32'(bus.addra), 32'd0);
    chk({nm, ".dia"}, 32'(bus.dia), 32'd0);
    chk({nm, ".in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({nm, ".busy"}, 32'(busy), 32'd1);
    chk({nm, ".col"}, 32'(cur_col), 32'd0);
    chk({nm, ".row"}, 32'(cur_row), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    //            v     d      wea   addr    dia    col   row
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 14'd0,  8'h00, 6'd0, 5'd0};
    vecs[1]  = '{1'b1, 8'h41, 1'b1, 14'd0,  8'h41, 6'd1, 5'd0};
    vecs[2]  = '{1'b1, 8'h42, 1'b1, 14'd1,  8'h42, 6'd2, 5'd0};
    vecs[3]  = '{1'b1, 8'h01, 1'b0, 14'd0,  8'h00, 6'd2, 5'd0};
    vecs[4]  = '{1'b1, 8'h0D, 1'b0, 14'd0,  8'h00, 6'd0, 5'd0};
    vecs[5]  = '{1'b1, 8'h08, 1'b0, 14'd0,  8'h00, 6'd0, 5'd0};
    vecs[6]  = '{1'b1, 8'h0A, 1'b0, 14'd0,  8'h00, 6'd0, 5'd1};
    vecs[7]  = '{1'b1, 8'h7E, 1'b1, 14'd40, 8'h7E, 6'd1, 5'd1};
    vecs[8]  = '{1'b1, 8'h7F, 1'b0, 14'd0,  8'h00, 6'd1, 5'd1};
    vecs[9]  = '{1'b1, 8'h08, 1'b1, 14'd40, 8'h20, 6'd0, 5'd1};
    vecs[10] = '{1'b1, 8'h20, 1'b1, 14'd40, 8'h20, 6'd1, 5'd1};

    repeat (3) @(posedge clk);
    #1;
    reset_vals("rst");
    rst_n = 1'b1;
    sweep("clr0", CELLS);
    after_clear("clr0_done");

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].v, vecs[i].d);
      expect_out($sformatf("vec%0d", i), vecs[i].wea, vecs[i].addr, vecs[i].dia,
                 vecs[i].col, vecs[i].row);
      chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
    end

    // Backspace at (5,3), then at column 0.
    step(1'b1, 8'h0A);
    step(1'b1, 8'h0A);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h61);
    step(1'b1, 8'h08);
    expect_out("bs_mid", 1'b1, 14'd124, 8'h20, 6'd4, 5'd3);
    step(1'b1, 8'h0D);
    step(1'b1, 8'h08);
    expect_out("bs_col0", 1'b0, 14'd0, 8'h00, 6'd0, 5'd3);

    // End-of-row wrap.
    for (int i = 0; i < 39; i++) step(1'b1, 8'h61);
    chk("row_end.col", 32'(cur_col), 32'd39);
    step(1'b1, 8'h58);
    expect_out("row_wrap", 1'b1, 14'd159, 8'h58, 6'd0, 5'd4);

    // LF on the last row.
    for (int i = 0; i < 20; i++) step(1'b1, 8'h0A);
    chk("last_row.row", 32'(cur_row), 32'd24);
    step(1'b1, 8'h0A);
    expect_out("lf_wrap", 1'b0, 14'd0, 8'h00, 6'd0, 5'd0);
`ifdef CHAR_CONSOLE_AUTOCLR_EN
    chk("lf_wrap.in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    sweep("clr_lf", CELLS);
    after_clear("clr_lf_done");
`else
    chk("lf_wrap.in_ready", 32'(bus.in_ready), 32'd1);
`endif

    // Printable at the last cell.
    for (int i = 0; i < 24; i++) step(1'b1, 8'h0A);
    for (int i = 0; i < 39; i++) step(1'b1, 8'h62);
    chk("last_cell.col", 32'(cur_col), 32'd39);
    chk("last_cell.row", 32'(cur_row), 32'd24);
    step(1'b1, 8'h51);
    expect_out("cell_wrap", 1'b1, 14'd999, 8'h51, 6'd0, 5'd0);
`ifdef CHAR_CONSOLE_AUTOCLR_EN
    chk("cell_wrap.in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    sweep("clr_cell", CELLS);
    after_clear("clr_cell_done");
`else
    chk("cell_wrap.in_ready", 32'(bus.in_ready), 32'd1);
`endif

    // Form feed with 'Z' held valid behind it.
    step(1'b1, 8'h0C);
    bus.in_data = 8'h5A;
    expect_out("ff", 1'b0, 14'd0, 8'h00, 6'd0, 5'd0);
    chk("ff.in_ready", 32'(bus.in_ready), 32'd0);
    chk("ff.busy", 32'(busy), 32'd1);
    sweep("clr_ff", CELLS);
    after_clear("clr_ff_done");
    @(posedge clk);
    #1;
    expect_out("z_after_ff", 1'b1, 14'd0, 8'h5A, 6'd1, 5'd0);
    bus.in_valid = 1'b0;

    // Reset in the middle of a sweep.
    step(1'b1, 8'h0C);
    bus.in_valid = 1'b0;
    sweep("clr_part", 501);
    chk("mid.addra", 32'(bus.addra), 32'd500);
    rst_n = 1'b0;
    #1;
    reset_vals("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep("clr_rst", CELLS);
    after_clear("clr_rst_done");
    step(1'b0, 8'h00);
    chk("post_rst.wea", 32'(bus.wea), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/char_ram_console_ctrl.md
Name: char_ram_console_ctrl

Overview:
- Write-side controller for the 1024x8 dual-port character RAM behind the text display.
- Accepts a byte stream over a valid/ready handshake, tracks a cursor on a COLS x ROWS grid and interprets control codes.
- Drives the RAM write port (wea/addra/dia). The display scan logic keeps exclusive use of the read port.

Parameters:
- COLS, 40, characters per row (1..64).
- ROWS, 25, rows on screen (1..32); COLS*ROWS must be <= 1024.
- FILL_CHAR, 8'h20, byte written by clear and backspace operations.

Ports:
- clk  input  1  single clock (RAM write clock clka is tied to it).
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte offered.
- in_data  input  8  byte value.
- in_ready  output  1  controller can accept a byte this cycle.
- wea  output  1  RAM write enable.
- addra  output  14  RAM write address.
- dia  output  8  RAM write data.
- cur_col  output  6  cursor column.
- cur_row  output  5  cursor row.
- busy  output  1  high while a clear sweep runs.

Behaviour:
- One clock domain; reset is asynchronous and active-low. All outputs are registered.
- While rst_n=0: wea=0, addra=0, dia=0, cur_col=0, cur_row=0, in_ready=0, busy=1, state=CLEAR, sweep counter=0.
- States:
  - CLEAR: sweep counter runs 0..COLS*ROWS-1 and writes FILL_CHAR to every cell (wea=1, addra=counter, dia=FILL_CHAR) on consecutive cycles.
    - Sweep length is exactly COLS*ROWS cycles. Cursor is forced to (0,0).
    - On the last write, go to IDLE: busy=0, in_ready=1 on the next cycle.
  - IDLE: in_ready=1. A byte is accepted when in_valid & in_ready.
    - Any resulting write appears on wea/addra/dia the cycle after acceptance (latency 1); otherwise wea=0.
    - One byte per cycle, sustained.
- Cursor address is row_base + col. row_base is a register stepped by COLS; no multiplier.
- Byte decoding in IDLE:
  - 0x20..0x7E: write the byte at the cursor, then advance the column.
    - col=COLS-1: col=0, row+1.
    - row=ROWS-1 and col=COLS-1: wrap to (0,0).
  - 0x0A (LF): col=0, row+1, wrapping to row 0 after ROWS-1. No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): if col>0, col-1 and write FILL_CHAR at the new position. If col=0, no-op (no row back-step).
  - 0x0C (FF): enter CLEAR. in_ready drops the following cycle. The FF byte itself is consumed.
  - Any other byte: consumed, no write, cursor unchanged.
- Simultaneous events: in_data/in_valid are ignored whenever in_ready=0. A byte held valid through CLEAR is accepted on the first IDLE cycle.
- Reset mid-sweep or mid-stream: immediate return to CLEAR from address 0. Partial writes are not resumed.
- After reset release, the first accepted byte cannot occur earlier than COLS*ROWS cycles later.

Optional Feature:
- Macro CHAR_CONSOLE_AUTOCLR_EN.
- Defined: the printable-at-last-cell wrap and the LF-on-last-row wrap enter CLEAR instead of moving to row 0. The byte that triggered it is written first; the sweep starts the following cycle; cursor ends at (0,0).
- Undefined: plain wrap to row 0 with no clear, existing text overwritten in place.

Decomposition:
- Shared package char_console_pkg:
  - control-code constants: CC_LF, CC_CR, CC_BS, CC_FF, PRINT_LO=8'h20, PRINT_HI=8'h7E;
  - state enumeration ST_CLEAR, ST_IDLE;
  - ADDR_W=14, DATA_W=8.
- One natural sub-module: char_cursor, holding col, row and row_base with advance, newline, carriage-return, backspace and home operations plus wrap/last-cell flags.
- The top level holds the FSM, sweep counter and write-port registers.

Test Plan:
- Reset, release, in_valid low -> wea=1 for exactly 1000 cycles, addra 0..999, dia=0x20; then busy=0, in_ready=1, cursor (0,0).
- After clear, send "AB" back-to-back -> writes (addra=0, 0x41) then (1, 0x42) on consecutive cycles one cycle after each accept; cursor (2,0).
- Send 39 printables, then 'X' -> 'X' written at addra=39; cursor (0,1). Send LF on row 24 -> cursor (0,0) with no write (macro off). With macro on: 1000-cycle clear starts, cursor (0,0).
- At (5,3) send BS -> write 0x20 at addra=124, cursor (4,3). At (0,3) send BS -> no write, cursor unchanged.
- Send FF while in_valid stays high with 'Z' queued behind it -> in_ready low for 1000 cycles; 'Z' then written at addra=0.
- Assert rst_n=0 at sweep address 500 -> outputs reset asynchronously; after release the sweep restarts at addra=0.
